// File: rtl/exception_vector_unit.sv
// Exception sequencer: saves EPC, fetches the handler byte from the vector table, then forces a PC load.
// Optional feature macro: EXC_CAUSE_REG_EN (cause register plus saturating exc_count output).
module exception_vector_unit #(
    parameter int unsigned VECTOR_BASE = 253,
    parameter int unsigned MEM_WAIT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    output logic [31:0] exception_destiny,
    output logic [31:0] epc_out,
    output logic        epc_write,
    output logic        pc_write,
    output logic        pc_src_force,
    output logic        busy,
`ifdef EXC_CAUSE_REG_EN
    output logic [7:0]  exc_count,
`endif
    output logic [1:0]  cause
);

    localparam int unsigned WAIT_W = 3;
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_WAIT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, JUMP} state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              any_exc;
    logic [1:0]        sel_offset;
    logic              unused_data;

    assign unused_data = ^mem_data_in[31:8];

    // Vector offset of the winning cause: opcode > div0 > overflow
    always_comb begin
        any_exc    = exc_opcode | exc_overflow | exc_div0;
        sel_offset = 2'd1;
        if (exc_opcode) begin
            sel_offset = 2'd0;
        end else if (exc_div0) begin
            sel_offset = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            wait_cnt          <= '0;
            mem_addr          <= '0;
            mem_req           <= 1'b0;
            exception_destiny <= '0;
            epc_out           <= '0;
            epc_write         <= 1'b0;
            pc_write          <= 1'b0;
            pc_src_force      <= 1'b0;
            busy              <= 1'b0;
`ifdef EXC_CAUSE_REG_EN
            cause             <= 2'd0;
            exc_count         <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_exc) begin
                        state     <= FETCH;
                        epc_out   <= pc_in - 32'd4;
                        mem_addr  <= 32'(VECTOR_BASE) + {30'b0, sel_offset};
                        wait_cnt  <= '0;
                        mem_req   <= 1'b1;
                        busy      <= 1'b1;
                        epc_write <= 1'b1;
`ifdef EXC_CAUSE_REG_EN
                        // Cause code is the vector offset plus one
                        cause     <= sel_offset + 2'd1;
                        if (exc_count != 8'hFF) begin
                            exc_count <= exc_count + 8'd1;
                        end
`endif
                    end
                end
                FETCH: begin
                    epc_write <= 1'b0;
                    if (wait_cnt == LAST_WAIT) begin
                        exception_destiny <= {24'b0, mem_data_in[7:0]};
                        state             <= JUMP;
                        mem_req           <= 1'b0;
                        pc_write          <= 1'b1;
                        pc_src_force      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                JUMP: begin
                    state        <= IDLE;
                    pc_write     <= 1'b0;
                    pc_src_force <= 1'b0;
                    busy         <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef EXC_CAUSE_REG_EN
    assign cause = 2'b00;
`endif

endmodule

// File: tb/tb_exception_vector_unit.sv
// Scoreboard bench for exception_vector_unit: driver pushes expected sequences from a cycle-level model,
// monitor pops and compares when the sequence completes and checks strobes every cycle.
module tb_exception_vector_unit;

    localparam int unsigned VB = 253;
    localparam int unsigned MW = 2;

    logic        clk;
    logic        reset;
    logic        exc_opcode;
    logic        exc_overflow;
    logic        exc_div0;
    logic [31:0] pc_in;
    logic [31:0] mem_data_in;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic [31:0] exception_destiny;
    logic [31:0] epc_out;
    logic        epc_write;
    logic        pc_write;
    logic        pc_src_force;
    logic        busy;
    logic [1:0]  cause;
`ifdef EXC_CAUSE_REG_EN
    logic [7:0]  exc_count;
`endif

    exception_vector_unit #(.VECTOR_BASE(VB), .MEM_WAIT(MW)) dut (
        .clk(clk),
        .reset(reset),
        .exc_opcode(exc_opcode),
        .exc_overflow(exc_overflow),
        .exc_div0(exc_div0),
        .pc_in(pc_in),
        .mem_data_in(mem_data_in),
        .mem_addr(mem_addr),
        .mem_req(mem_req),
        .exception_destiny(exception_destiny),
        .epc_out(epc_out),
        .epc_write(epc_write),
        .pc_write(pc_write),
        .pc_src_force(pc_src_force),
        .busy(busy),
`ifdef EXC_CAUSE_REG_EN
        .exc_count(exc_count),
`endif
        .cause(cause)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] epc;
        logic [31:0] dest;
        logic [1:0]  cause;
        logic [7:0]  cnt;
        int          wcyc;
    } txn_t;

    txn_t       q[$];
    int         cyc = 0;
    int         nvec = 0;
    int         nerr = 0;
    logic [7:0] vt [3];
    int         busy_until = -100;
    int         zero_cyc = -1;
    logic       pend_valid = 1'b0;
    int         pend_acc = 0;
    logic [7:0] pend_dest = 8'd0;
    int         mcount = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs and advance the reference model
    task automatic step(input logic op, input logic ov, input logic dz, input logic rst,
                        input logic [31:0] pc);
        logic [31:0] g;
        int          c;
        int          idx;
        txn_t        t;
        @(negedge clk);
        c = cyc;
        g = $urandom;
        if (pend_valid && c == pend_acc + int'(MW)) begin
            g[7:0] = pend_dest;
        end else if (pend_valid && g[7:0] == pend_dest) begin
            g[7:0] = ~pend_dest;
        end
        mem_data_in  = g;
        exc_opcode   = op;
        exc_overflow = ov;
        exc_div0     = dz;
        reset        = rst;
        pc_in        = pc;
        if (rst) begin
            if (pend_valid && busy_until > c && q.size() > 0) void'(q.pop_back());
            pend_valid = 1'b0;
            busy_until = c;
            zero_cyc   = c + 1;
            mcount     = 0;
        end else if (c > busy_until && (op || ov || dz)) begin
            idx = op ? 0 : (dz ? 2 : 1);
            mcount = (mcount >= 255) ? 255 : mcount + 1;
            t.addr = VB + 32'(idx);
            t.epc  = pc - 32'd4;
            t.dest = {24'd0, vt[idx]};
`ifdef EXC_CAUSE_REG_EN
            t.cause = 2'(idx + 1);
`else
            t.cause = 2'd0;
`endif
            t.cnt  = 8'(mcount);
            t.wcyc = c + int'(MW) + 1;
            q.push_back(t);
            busy_until = t.wcyc;
            pend_valid = 1'b1;
            pend_acc   = c;
            pend_dest  = vt[idx];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    endtask

    // Monitor: per-cycle strobe checks and scoreboard pop at the PC load
    initial begin
        txn_t t;
        logic e_busy, e_req, e_ew, e_pw;
        forever begin
            @(posedge clk);
            #1;
            if (cyc >= 2) begin
                e_busy = 1'b0; e_req = 1'b0; e_ew = 1'b0; e_pw = 1'b0;
                if (q.size() > 0) begin
                    t = q[0];
                    e_busy = (cyc >= t.wcyc - int'(MW)) && (cyc <= t.wcyc);
                    e_req  = (cyc >= t.wcyc - int'(MW)) && (cyc < t.wcyc);
                    e_ew   = (cyc == t.wcyc - int'(MW));
                    e_pw   = (cyc == t.wcyc);
                end
                check("busy", 32'(busy), 32'(e_busy));
                check("mem_req", 32'(mem_req), 32'(e_req));
                check("epc_write", 32'(epc_write), 32'(e_ew));
                check("pc_write", 32'(pc_write), 32'(e_pw));
                check("pc_src_force", 32'(pc_src_force), 32'(e_pw));
                if (e_req) check("mem_addr", mem_addr, t.addr);
                if (e_ew) check("epc_at_write", epc_out, t.epc);
                if (e_pw) begin
                    check("exception_destiny", exception_destiny, t.dest);
                    check("epc_out", epc_out, t.epc);
                    check("mem_addr_hold", mem_addr, t.addr);
                    check("cause", 32'(cause), 32'(t.cause));
`ifdef EXC_CAUSE_REG_EN
                    check("exc_count", 32'(exc_count), 32'(t.cnt));
`endif
                    void'(q.pop_front());
                end
                if (cyc == zero_cyc) begin
                    check("reset_mem_addr", mem_addr, 32'd0);
                    check("reset_destiny", exception_destiny, 32'd0);
                    check("reset_epc", epc_out, 32'd0);
                    check("reset_cause", 32'(cause), 32'd0);
`ifdef EXC_CAUSE_REG_EN
                    check("reset_exc_count", 32'(exc_count), 32'd0);
`endif
                end
            end
        end
    end

    initial begin
        int r;
        reset = 1'b1; exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0;
        pc_in = 32'd0; mem_data_in = 32'd0;
        vt[0] = 8'($urandom); vt[1] = 8'h8C; vt[2] = 8'($urandom);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        idle(3);
        // Overflow with pc 0x40 and handler byte 0x8C
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h40);
        idle(5);
        // All three causes at once
        step(1'b1, 1'b1, 1'b1, 1'b0, $urandom);
        idle(5);
        // div0 then overflow held while busy and one cycle past
        step(1'b0, 1'b0, 1'b1, 1'b0, $urandom);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h1000 + 32'(i));
        idle(5);
        // EPC wrap
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        idle(5);
        // Reset mid-FETCH, then a normal sequence
        step(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
        idle(1);
        step(1'b0, 1'b0, 1'b0, 1'b1, $urandom);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 1'b0, $urandom);
        idle(5);
        // Randomized traffic including resets coinciding with exceptions
        for (int i = 0; i < 500; i++) begin
            r = int'($urandom_range(0, 99));
            step($urandom_range(0, 99) < 12, $urandom_range(0, 99) < 12,
                 $urandom_range(0, 99) < 12, r < 3, $urandom);
        end
        idle(5);
`ifdef EXC_CAUSE_REG_EN
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        for (int i = 0; i < 260; i++) begin
            r = int'($urandom_range(0, 2));
            step(r == 0, r == 1, r == 2, 1'b0, $urandom);
            idle(int'(MW) + 1);
        end
`endif
        idle(10);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/exception_vector_unit.md
# exception_vector_unit

Sequential exception handler sitting directly upstream of the PC source multiplexer; it produces that mux's `Exception_Destiny` input (select 0) and the EPC value feeding its `EPC_Out` input (select 1). On an invalid-opcode, overflow or divide-by-zero event it:
- saves the faulting instruction address;
- reads the handler address byte from the fixed vector table in memory;
- requests a PC load through mux select 0.

The control unit stalls normal sequencing while `busy` is high.

## Interface
Parameters:
- `VECTOR_BASE`, 253: byte address of the opcode vector. Vectors are at base+0 (opcode), base+1 (overflow), base+2 (div0).
- `MEM_WAIT`, 2: cycles `mem_addr` is held before read data is sampled; legal range 1..7.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `exc_opcode`  in  1  invalid opcode detected
- `exc_overflow`  in  1  ALU overflow detected
- `exc_div0`  in  1  divide by zero detected
- `pc_in`  in  32  current PC, already incremented (PC+4)
- `mem_data_in`  in  32  memory read data; only bits [7:0] are used
- `mem_addr`  out  32  vector address driven to the memory address mux
- `mem_req`  out  1  high while `mem_addr` is valid
- `exception_destiny`  out  32  handler address, zero-extended byte
- `epc_out`  out  32  saved EPC
- `epc_write`  out  1  one-cycle EPC register write strobe
- `pc_write`  out  1  one-cycle PC load strobe
- `pc_src_force`  out  1  forces PC source select to 0 (Exception_Destiny); high in the same cycle as `pc_write`
- `busy`  out  1  exception sequence in progress
- `cause`  out  2  last cause: 1 opcode, 2 overflow, 3 div0, 0 none

## Operation
- FSM states: IDLE, FETCH, JUMP.
- **IDLE:**
  - If any exception input is high at a rising edge, latch the cause and latch `epc_out = pc_in - 4` (32-bit, wraps modulo 2^32).
  - Latch `mem_addr = VECTOR_BASE + offset` and clear the wait counter.
  - Go to FETCH.
- **Priority** when several inputs are high in the same cycle: opcode > div0 > overflow. Only the winner is recorded; losers are dropped.
- **FETCH:**
  - `mem_req = 1`, `busy = 1`; `epc_write = 1` in the first FETCH cycle only.
  - The counter increments each cycle. After `MEM_WAIT` FETCH cycles, the edge latches `exception_destiny = {24'b0, mem_data_in[7:0]}` and the FSM goes to JUMP.
- **JUMP:** `pc_write = 1`, `pc_src_force = 1`, `busy = 1`, `mem_req = 0`; next state is IDLE.
- Exception inputs are ignored in FETCH and JUMP; there is no queuing.
- A new exception may be accepted in the IDLE cycle immediately after JUMP.
- `mem_addr`, `exception_destiny` and `epc_out` hold their values until the next accepted exception.
- **Reset**, at any time including mid-sequence:
  - The FSM returns to IDLE at the next edge.
  - `mem_addr`, `exception_destiny`, `epc_out` and `cause` are cleared to 0.
  - All strobes, `mem_req` and `busy` go to 0.
  - A partially fetched vector is discarded.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- Exception sampled at the edge ending cycle 0:
  - cycles 1..MEM_WAIT are FETCH (`epc_write` in cycle 1);
  - cycle MEM_WAIT+1 is JUMP;
  - `busy` falls in cycle MEM_WAIT+2.
- Default latency, trigger edge to `pc_write`: 3 cycles. `busy` is high for MEM_WAIT+1 cycles.
- `mem_data_in` is sampled at the edge ending the last FETCH cycle, i.e. MEM_WAIT cycles after `mem_addr` became valid.
- Reset asserted in the same cycle as an exception input: reset wins and the exception is lost.

## Configuration
- `EXC_CAUSE_REG_EN` defined:
  - `cause` is a register, updated on each accepted exception and cleared only by reset.
  - An 8-bit saturating `exc_count` output is added, incremented per accepted exception and stopping at 255.
- Not defined: `cause` is tied to 2'b00, `exc_count` is absent, and no cause storage is synthesised.

## Test plan
- **Overflow.** Reset, then `exc_overflow = 1` for one cycle with `pc_in = 0x40` and `mem_data_in[7:0] = 0x8C`.
  - Required: `mem_addr = 254` for 2 cycles, `epc_out = 0x3C` with `epc_write` in cycle 1, `exception_destiny = 0x8C`, `pc_write` and `pc_src_force` in cycle 3.
- **Simultaneous causes.** `exc_opcode`, `exc_div0` and `exc_overflow` all high in the same cycle.
  - Required: `mem_addr = 253`, and `cause = 1` when `EXC_CAUSE_REG_EN` is defined.
- **Inputs while busy.** `exc_div0` pulsed at cycle 0, then `exc_overflow` held high during cycles 1-3.
  - Required: only one sequence, `mem_addr = 255`. A second sequence with `mem_addr = 254` starts at cycle 4 if `exc_overflow` is still high.
- **EPC wrap.** `pc_in = 0x00000000` on exception.
  - Required: `epc_out = 0xFFFFFFFC`.
- **Reset mid-FETCH.** Assert `reset` in cycle 2.
  - Required: no `pc_write`; all outputs 0 from cycle 3; the next exception is handled normally.
- **Counter saturation** (`EXC_CAUSE_REG_EN` only). Drive 256 exceptions.
  - Required: `exc_count` saturates at 255.
